// File: rtl/anc_pkg.sv
// Shared encodings, FSM states and fixed-point helpers for the multi-channel LMS engine.
package anc_pkg;

  typedef enum logic [1:0] {
    MODE_ADAPT  = 2'b00,
    MODE_FREEZE = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CLR,
    ST_OUT
  } state_e;

  // Guard bits cover the sum of TAPS full-scale products.
  function automatic int acc_width(input int w, input int taps);
    return 2 * w + $clog2(taps);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r  = v;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/anc_lms_engine_if.sv
// Frame-in / result-out handshake bundle between the front end, the engine and the DAC path.
interface anc_lms_engine_if #(
  parameter int W    = 16,
  parameter int CH   = 2,
  parameter int MU_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [CH*W-1:0]   x_in;
  logic [CH*W-1:0]   e_in;
  logic [MU_W-1:0]   mu_shift;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [CH*W-1:0]   y_out;
  logic              busy;

  modport master (
    output in_valid, x_in, e_in, mu_shift, mode, out_ready,
    input  in_ready, out_valid, y_out, busy
  );

  modport slave (
    input  in_valid, x_in, e_in, mu_shift, mode, out_ready,
    output in_ready, out_valid, y_out, busy
  );
endinterface

// File: rtl/anc_lms_mac.sv
// Single shared tap datapath: LMS weight update with saturation, tap multiply and accumulate.
module anc_lms_mac
  import anc_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = 36,
  parameter int MU_W  = 5
) (
  input  logic                    adapt,
  input  logic                    first,
  input  logic [MU_W-1:0]         mu,
  input  logic signed [W-1:0]     e,
  input  logic signed [W-1:0]     hk,
  input  logic signed [W-1:0]     wk,
  input  logic signed [W-1:0]     hn,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [W-1:0]     w_new,
  output logic signed [ACC_W-1:0] acc_out,
  output logic signed [W-1:0]     y_sat
);
  logic signed [2*W-1:0]   prod, upd, wsum;
  logic signed [ACC_W-1:0] acc_base, tap_prod, acc_sh;

  always_comb begin
    prod = (2*W)'(e) * (2*W)'(hk);
    upd  = '0;
    // Large step shifts would floor negative products to -1; force a true zero update.
    if (int'(mu) < W) upd = prod >>> (W - 1 + int'(mu));
    wsum     = (2*W)'(wk) + upd;
    w_new    = adapt ? W'(sat(64'(wsum), W)) : wk;
    tap_prod = ACC_W'(w_new) * ACC_W'(hn);
    acc_base = first ? ACC_W'(0) : acc_in;
    acc_out  = acc_base + tap_prod;
    acc_sh   = acc_out >>> (W - 1);
    y_sat    = W'(sat(64'(acc_sh), W));
  end
endmodule

// File: rtl/anc_lms_engine.sv
// Multi-channel adaptive FIR with in-place LMS update, time-multiplexed over one MAC.
//   state   | meaning
//   IDLE    | waiting for a frame, in_ready high
//   RUN     | one tap per cycle, channel-major, adapt or freeze
//   CLR     | zeroing one tap index per cycle across all channels
//   OUT     | y_out valid, held until out_ready
module anc_lms_engine
  import anc_pkg::*;
#(
  parameter int W    = 16,
  parameter int TAPS = 16,
  parameter int CH   = 2,
  parameter int MU_W = 5
) (
  input logic            clk,
  input logic            rst,
  anc_lms_engine_if.slave bus
);
  localparam int KW    = $clog2(TAPS);
  localparam int N     = CH * TAPS;
  localparam int CNT_W = $clog2(N);
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int ACC_W = acc_width(W, TAPS);

  state_e                  state, state_d;
  mode_e                   mode_r;
  logic [MU_W-1:0]         mu_r;
  logic [CNT_W-1:0]        cnt, idx;
  logic [KW-1:0]           k_idx;
  logic [CW-1:0]           c_idx;
  logic signed [W-1:0]     x_r [CH];
  logic signed [W-1:0]     e_r [CH];
  logic signed [W-1:0]     y_r [CH];
  logic signed [W-1:0]     w_mem [CH][TAPS];
  logic signed [W-1:0]     h_mem [CH][TAPS];
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [W-1:0]     hn, w_new, y_sat;
  logic                    accept, tc, last_tap;

  assign accept   = bus.in_valid && (state == ST_IDLE);
  // Step index counts up as the timer counts down; low bits give the tap in both RUN and CLR.
  assign idx      = CNT_W'(N - 1) - cnt;
  assign k_idx    = idx[KW-1:0];
  assign c_idx    = CW'(idx >> KW);
  assign tc       = (cnt == '0);
  assign last_tap = (k_idx == KW'(TAPS - 1));
  assign hn       = (k_idx == '0) ? x_r[c_idx] : h_mem[c_idx][k_idx - KW'(1)];

  anc_lms_mac #(.W(W), .ACC_W(ACC_W), .MU_W(MU_W)) u_mac (
    .adapt   (mode_r == MODE_ADAPT),
    .first   (k_idx == '0),
    .mu      (mu_r),
    .e       (e_r[c_idx]),
    .hk      (h_mem[c_idx][k_idx]),
    .wk      (w_mem[c_idx][k_idx]),
    .hn      (hn),
    .acc_in  (acc),
    .w_new   (w_new),
    .acc_out (acc_nxt),
    .y_sat   (y_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (accept) begin
        unique case (mode_e'(bus.mode))
          MODE_BYPASS: state_d = ST_OUT;
          MODE_CLEAR:  state_d = ST_CLR;
          default:     state_d = ST_RUN;
        endcase
      end
      ST_RUN, ST_CLR: if (tc) state_d = ST_OUT;
      ST_OUT:  if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mu_r   <= '0;
      mode_r <= MODE_ADAPT;
      for (int c = 0; c < CH; c++) begin
        x_r[c] <= '0;
        e_r[c] <= '0;
        y_r[c] <= '0;
        for (int k = 0; k < TAPS; k++) begin
          w_mem[c][k] <= '0;
          h_mem[c][k] <= '0;
        end
      end
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          mode_r <= mode_e'(bus.mode);
          mu_r   <= bus.mu_shift;
          cnt    <= (mode_e'(bus.mode) == MODE_CLEAR) ? CNT_W'(TAPS - 1) : CNT_W'(N - 1);
          for (int c = 0; c < CH; c++) begin
            x_r[c] <= bus.x_in[c*W +: W];
            e_r[c] <= bus.e_in[c*W +: W];
            if (mode_e'(bus.mode) == MODE_BYPASS)     y_r[c] <= bus.x_in[c*W +: W];
            else if (mode_e'(bus.mode) == MODE_CLEAR) y_r[c] <= '0;
          end
        end
        ST_RUN: begin
          cnt                 <= cnt - CNT_W'(1);
          acc                 <= acc_nxt;
          w_mem[c_idx][k_idx] <= w_new;
          // History shifts only after the channel's last tap so every tap sees the old line.
          if (last_tap) begin
            y_r[c_idx]      <= y_sat;
            h_mem[c_idx][0] <= x_r[c_idx];
            for (int k = 1; k < TAPS; k++) h_mem[c_idx][k] <= h_mem[c_idx][k-1];
          end
        end
        ST_CLR: begin
          cnt <= cnt - CNT_W'(1);
          for (int c = 0; c < CH; c++) w_mem[c][k_idx] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.busy      = (state == ST_RUN) || (state == ST_CLR);

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign bus.y_out[g*W +: W] = y_r[g];
  end
endmodule

// File: tb/tb_anc_lms_engine.sv
// Bench for anc_lms_engine: directed vector table, corner sequences, random frames vs a frame-level model.
module tb_anc_lms_engine;
  import anc_pkg::*;

  localparam int W    = 16;
  localparam int TAPS = 16;
  localparam int CH   = 2;
  localparam int MU_W = 5;
  localparam int PW   = CH * W;

  typedef struct {
    string         name;
    logic [PW-1:0] x;
    logic [PW-1:0] e;
    int            mu;
    int            md;
    logic [PW-1:0] y;
    int            lat;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     failures = 0;
  longint mw [CH][TAPS];
  longint mh [CH][TAPS];
  vec_t   tv [9];

  always #5 clk = ~clk;

  anc_lms_engine_if #(.W(W), .CH(CH), .MU_W(MU_W)) bus ();

  anc_lms_engine #(.W(W), .TAPS(TAPS), .CH(CH), .MU_W(MU_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input string n, input logic [PW-1:0] x, input logic [PW-1:0] e,
                              input int mu, input int md, input logic [PW-1:0] y, input int lat);
    vec_t v;
    v.name = n; v.x = x; v.e = e; v.mu = mu; v.md = md; v.y = y; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_y(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    for (int c = 0; c < CH; c++)
      check($sformatf("%s_y%0d", name, c), longint'($signed(act[c*W +: W])),
            longint'($signed(exp[c*W +: W])));
  endtask

  function automatic longint msat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int exp_lat(input int md);
    if (md == 2) return 1;
    if (md == 3) return TAPS + 1;
    return CH * TAPS + 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) begin
        mw[c][k] = 0;
        mh[c][k] = 0;
      end
  endtask

  // Frame-level reference: whole-frame arithmetic on integer arrays.
  task automatic model_frame(input logic [PW-1:0] xp, input logic [PW-1:0] ep, input int mu,
                             input int md, output logic [PW-1:0] yp);
    longint xs, es, acc, hn, ys;
    yp = '0;
    for (int c = 0; c < CH; c++) begin
      xs = longint'($signed(xp[c*W +: W]));
      es = longint'($signed(ep[c*W +: W]));
      if (md == 2) begin
        yp[c*W +: W] = xp[c*W +: W];
      end else if (md == 3) begin
        for (int k = 0; k < TAPS; k++) mw[c][k] = 0;
      end else begin
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
          if (md == 0 && mu < W)
            mw[c][k] = msat(mw[c][k] + ((es * mh[c][k]) >>> (W - 1 + mu)));
          if (k == 0) hn = xs;
          else        hn = mh[c][k-1];
          acc += mw[c][k] * hn;
        end
        ys = msat(acc >>> (W - 1));
        yp[c*W +: W] = ys[W-1:0];
        for (int k = TAPS - 1; k > 0; k--) mh[c][k] = mh[c][k-1];
        mh[c][0] = xs;
      end
    end
  endtask

  // Offers a frame, scrambles the inputs after accept, waits for out_valid, optionally stalls.
  task automatic send(input logic [PW-1:0] x, input logic [PW-1:0] e, input int mu, input int md,
                      input int hold, output logic [PW-1:0] y, output int lat);
    int n;
    bit stable, blocked;
    bus.x_in = x; bus.e_in = e; bus.mu_shift = MU_W'(mu); bus.mode = 2'(md);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_in = PW'($urandom); bus.e_in = PW'($urandom);
    bus.mu_shift = MU_W'($urandom); bus.mode = 2'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    y = bus.y_out;
    if (hold > 0) begin
      stable = 1; blocked = 1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (bus.y_out !== y || bus.out_valid !== 1'b1) stable = 0;
        if (bus.in_ready !== 1'b0) blocked = 0;
      end
      bus.in_valid = 1'b0;
      check("hold_y_stable", stable, 1);
      check("hold_in_ready_low", blocked, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_handshake", bus.in_ready, 1);
  endtask

  task automatic run_vs_model(input string name, input logic [PW-1:0] x, input logic [PW-1:0] e,
                              input int mu, input int md, input int hold, output logic [PW-1:0] yd);
    logic [PW-1:0] ym;
    int lat;
    send(x, e, mu, md, hold, yd, lat);
    model_frame(x, e, mu, md, ym);
    check_y(name, yd, ym);
    check({name, "_lat"}, lat, exp_lat(md));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] yd, ym;
    int            lat, r, md;
    bit            pulse;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x_in = '0; bus.e_in = '0; bus.mu_shift = '0; bus.mode = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_y_out", bus.y_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    tv[0] = mk("adapt_first",  {16'h0000, 16'h4000}, 32'h0,                0,  0, 32'h0,                33);
    tv[1] = mk("adapt_err",    32'h0,                {16'h0000, 16'h4000}, 0,  0, 32'h0,                33);
    tv[2] = mk("adapt_out",    {16'h0000, 16'h4000}, 32'h0,                0,  0, {16'h0000, 16'h1000}, 33);
    tv[3] = mk("bypass",       {16'h8000, 16'h1234}, 32'h0,                0,  2, {16'h8000, 16'h1234}, 1);
    tv[4] = mk("freeze_same",  {16'h0000, 16'h4000}, 32'h0,                0,  1, {16'h0000, 16'h1000}, 33);
    tv[5] = mk("clear",        {16'h7777, 16'h5555}, {16'h1111, 16'h2222}, 0,  3, 32'h0,                17);
    tv[6] = mk("post_clear",   {16'h1111, 16'h5555}, 32'h0,                0,  0, 32'h0,                33);
    tv[7] = mk("mu_ge_w",      {16'h0000, 16'h1000}, {16'h7FFF, 16'h7FFF}, 20, 0, 32'h0,                33);
    tv[8] = mk("mu_ge_w_chk",  {16'h0000, 16'h1000}, 32'h0,                0,  1, 32'h0,                33);

    for (int i = 0; i < 9; i++) begin
      send(tv[i].x, tv[i].e, tv[i].mu, tv[i].md, 0, yd, lat);
      model_frame(tv[i].x, tv[i].e, tv[i].mu, tv[i].md, ym);
      check_y(tv[i].name, yd, tv[i].y);
      check_y({tv[i].name, "_model"}, yd, ym);
      check({tv[i].name, "_lat"}, lat, tv[i].lat);
    end

    for (int i = 0; i < 20; i++)
      run_vs_model("sat_drive", {16'h0000, 16'h7FFF}, {16'h0000, 16'h7FFF}, 0, 0, 0, yd);
    check("sat_y0_max", longint'($signed(yd[W-1:0])), 32767);

    run_vs_model("hold", {16'h0000, 16'h7FFF}, 32'h0, 0, 1, 10, yd);

    bus.x_in = {16'h1234, 16'h7FFF}; bus.e_in = {16'h7FFF, 16'h8000};
    bus.mu_shift = '0; bus.mode = 2'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("abort_busy_run", bus.busy, 1);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready_async", bus.in_ready, 1);
    check("abort_busy_async", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    pulse = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulse = 1;
    end
    check("abort_no_out_valid", pulse, 0);
    check("abort_in_ready", bus.in_ready, 1);
    run_vs_model("wzero_a", {16'h7FFF, 16'h7FFF}, 32'h0, 0, 1, 0, yd);
    check("wzero_a_y0", longint'($signed(yd[W-1:0])), 0);
    run_vs_model("wzero_b", {16'h7FFF, 16'h7FFF}, 32'h0, 0, 1, 0, yd);
    check("wzero_b_y1", longint'($signed(yd[PW-1:W])), 0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      md = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      run_vs_model($sformatf("rand%0d", i), PW'($urandom), PW'($urandom),
                   $urandom_range(0, 20), md, $urandom_range(0, 2), yd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
